config_port_arbiter: RTL and testbench
======================================

Name: config_port_arbiter

Overview:
Sequential arbiter that shares the single fabric configuration write path (ConfigWriteData/ConfigWriteStrobe into ConfigFSM) between three sources: the UART loader, the bit-bang loader and the CPU self-write port. Ownership is session-based with fixed priority UART > bit-bang > CPU and pre-emption. FsmReset pulses on every ownership change, so a partially received frame is never merged with another source's data. All outputs are registered.

Parameters:
TIMEOUT_CYCLES, 1024, idle cycles without a CPU strobe before a CPU session ends (minimum 2)
CNT_WIDTH, 10, width of the CPU idle counter; must satisfy 2^CNT_WIDTH >= TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock; all logic on the rising edge
resetn  in  1  synchronous, active-low reset
uart_active  in  1  UART loader session active (ComActive)
uart_data  in  32  UART write word
uart_strobe  in  1  UART word valid (1-cycle pulse)
bb_active  in  1  bit-bang session active
bb_data  in  32  bit-bang write word
bb_strobe  in  1  bit-bang word valid
cpu_data  in  32  CPU self-write word
cpu_strobe  in  1  CPU self-write word valid
ConfigWriteData  out  32  word forwarded to ConfigFSM
ConfigWriteStrobe  out  1  forwarded word valid
FsmReset  out  1  ConfigFSM reset pulse
Owner  out  2  00 idle, 01 UART, 10 bit-bang, 11 CPU
cpu_drop  out  1  1-cycle pulse: a CPU strobe was rejected

Behaviour:
- States: IDLE, OWN_UART, OWN_BB, OWN_CPU, HANDOVER. HANDOVER holds a registered target.
- Reset: resetn low at an edge forces the following:
  - state IDLE, counter 0, target cleared
  - ConfigWriteData 0, ConfigWriteStrobe 0, Owner 00, cpu_drop 0
  - FsmReset 1; it deasserts on the first edge with resetn high
  - Any reset mid-session aborts the session. No word is forwarded during reset.
- Forwarding:
  - Owner's strobe at edge t gives ConfigWriteStrobe=1 and ConfigWriteData=owner data at t+1.
  - Otherwise ConfigWriteStrobe=0 and ConfigWriteData holds its last value.
  - Latency is exactly 1 cycle.
- IDLE:
  - uart_active wins first. Go to OWN_UART with a FsmReset pulse at t+1.
  - Else bb_active: go to OWN_BB with a FsmReset pulse.
  - Else cpu_strobe: go to OWN_CPU with a FsmReset pulse, and forward the triggering CPU word at t+1. The first word is never lost.
  - A uart/bb strobe arriving in the grant cycle is forwarded.
- OWN_UART: stays while uart_active.
  - On uart_active low: if bb_active, go to HANDOVER(target BB); else go to IDLE (no pulse).
- OWN_BB: stays while bb_active and not uart_active.
  - uart_active high pre-empts: HANDOVER(UART).
  - bb_active low with uart_active low: IDLE.
- OWN_CPU:
  - Counter clears on each forwarded CPU strobe; otherwise it increments.
  - Counter reaching TIMEOUT_CYCLES-1 goes to IDLE.
  - uart_active pre-empts to HANDOVER(UART); else bb_active pre-empts to HANDOVER(BB).
  - A CPU strobe in the same cycle as a pre-emption is dropped.
- HANDOVER: lasts exactly 1 cycle.
  - FsmReset=1, ConfigWriteStrobe=0, Owner=00.
  - Strobes received during HANDOVER are not forwarded.
  - Next state is OWN_target. If target's active dropped meanwhile, go to IDLE instead.
- FsmReset:
  - 1-cycle pulse on every grant (IDLE→OWN_x) and during HANDOVER.
  - Never asserted in two consecutive cycles, except during and right after reset.
- cpu_drop: pulses at t+1 for any cpu_strobe at t not forwarded (CPU not owner, HANDOVER, or pre-emption cycle).
- Ignored inputs: uart/bb strobes from a non-owner, or with their active low, are silently ignored.
- Simultaneous events:
  - uart_active and bb_active rising together: UART wins.
  - All three requesting in IDLE: UART wins, and cpu_drop pulses.
- Owner output: registered and equal to the current state encoding.

Test Plan:
- Reset: resetn low 3 cycles with all inputs toggling, then release → outputs 0 and Owner=00; FsmReset=1 through the first edge after release, then 0.
- CPU session: cpu_strobe with 0xDEADBEEF in IDLE → next cycle Owner=11, FsmReset=1, ConfigWriteStrobe=1, data 0xDEADBEEF. Idle 1023 cycles → Owner=00; a strobe at idle cycle 1022 restarts the count.
- UART pre-empts CPU: during OWN_CPU raise uart_active while cpu_strobe=1 → cpu_drop pulse, 1 HANDOVER cycle (FsmReset=1, Owner=00), then Owner=01. A uart_strobe 0x12345678 is forwarded 1 cycle later.
- UART pre-empts BB: bb session forwarding words, then uart_active rises → HANDOVER then OWN_UART. After uart_active falls with bb_active still high → HANDOVER then OWN_BB.
- Simultaneous: uart_active, bb_active and cpu_strobe asserted together in IDLE → Owner=01, cpu_drop=1, no bb word forwarded.
- Mid-session reset: resetn low during a UART word burst → no strobe out, Owner=00. Once resetn is high with uart_active still high → re-grant UART with a FsmReset pulse.

Source files
------------

// File: rtl/config_port_arbiter_if.sv
// Source and ConfigFSM signals of the configuration port arbiter.
// master is the arbiter's view; slave is the view of its surroundings.
interface config_port_arbiter_if;
    logic        uart_active;
    logic [31:0] uart_data;
    logic        uart_strobe;
    logic        bb_active;
    logic [31:0] bb_data;
    logic        bb_strobe;
    logic [31:0] cpu_data;
    logic        cpu_strobe;
    logic [31:0] ConfigWriteData;
    logic        ConfigWriteStrobe;
    logic        FsmReset;
    logic [1:0]  Owner;
    logic        cpu_drop;

    modport master (
        input  uart_active, uart_data, uart_strobe,
        input  bb_active, bb_data, bb_strobe,
        input  cpu_data, cpu_strobe,
        output ConfigWriteData, ConfigWriteStrobe,
        output FsmReset, Owner, cpu_drop
    );

    modport slave (
        output uart_active, uart_data, uart_strobe,
        output bb_active, bb_data, bb_strobe,
        output cpu_data, cpu_strobe,
        input  ConfigWriteData, ConfigWriteStrobe,
        input  FsmReset, Owner, cpu_drop
    );
endinterface

// File: rtl/config_port_arbiter.sv
// Session arbiter sharing the ConfigFSM write path between UART,
// bit-bang and CPU sources (UART > bit-bang > CPU, with pre-emption).
module config_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 10
) (
    input logic                  CLK,
    input logic                  resetn,
    config_port_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OWN_UART = 3'd1,
        OWN_BB   = 3'd2,
        OWN_CPU  = 3'd3,
        HANDOVER = 3'd4
    } state_t;

    localparam logic [1:0] TGT_NONE = 2'b00;
    localparam logic [1:0] TGT_UART = 2'b01;
    localparam logic [1:0] TGT_BB   = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 2);

    state_t               state_q, state_d;
    logic [1:0]           tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic                 fsm_reset_q, fsm_reset_d;
    logic [1:0]           owner_q, owner_d;
    logic                 drop_q, drop_d;
    logic                 cpu_fwd;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        fsm_reset_d = 1'b0;
        cpu_fwd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.uart_active) begin
                    state_d     = OWN_UART;
                    fsm_reset_d = 1'b1;
                    if (bus.uart_strobe) begin
                        strobe_d = 1'b1;
                        data_d   = bus.uart_data;
                    end
                end else if (bus.bb_active) begin
                    state_d     = OWN_BB;
                    fsm_reset_d = 1'b1;
                    if (bus.bb_strobe) begin
                        strobe_d = 1'b1;
                        data_d   = bus.bb_data;
                    end
                end else if (bus.cpu_strobe) begin
                    // the word that opens a CPU session is forwarded too
                    state_d     = OWN_CPU;
                    fsm_reset_d = 1'b1;
                    cpu_fwd     = 1'b1;
                    strobe_d    = 1'b1;
                    data_d      = bus.cpu_data;
                end
            end
            OWN_UART: begin
                if (bus.uart_active) begin
                    if (bus.uart_strobe) begin
                        strobe_d = 1'b1;
                        data_d   = bus.uart_data;
                    end
                end else if (bus.bb_active) begin
                    state_d     = HANDOVER;
                    tgt_d       = TGT_BB;
                    fsm_reset_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_BB: begin
                if (bus.uart_active) begin
                    state_d     = HANDOVER;
                    tgt_d       = TGT_UART;
                    fsm_reset_d = 1'b1;
                end else if (bus.bb_active) begin
                    if (bus.bb_strobe) begin
                        strobe_d = 1'b1;
                        data_d   = bus.bb_data;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_CPU: begin
                if (bus.uart_active) begin
                    state_d     = HANDOVER;
                    tgt_d       = TGT_UART;
                    fsm_reset_d = 1'b1;
                end else if (bus.bb_active) begin
                    state_d     = HANDOVER;
                    tgt_d       = TGT_BB;
                    fsm_reset_d = 1'b1;
                end else if (bus.cpu_strobe) begin
                    cpu_fwd  = 1'b1;
                    strobe_d = 1'b1;
                    data_d   = bus.cpu_data;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HANDOVER: begin
                // target may have given up while ConfigFSM was resetting
                tgt_d = TGT_NONE;
                if (tgt_q == TGT_UART && bus.uart_active) begin
                    state_d = OWN_UART;
                end else if (tgt_q == TGT_BB && bus.bb_active) begin
                    state_d = OWN_BB;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tgt_d   = TGT_NONE;
            end
        endcase

        if (state_d != OWN_CPU) begin
            cnt_d = '0;
        end

        drop_d = bus.cpu_strobe & ~cpu_fwd;

        unique case (state_d)
            OWN_UART: owner_d = 2'b01;
            OWN_BB:   owner_d = 2'b10;
            OWN_CPU:  owner_d = 2'b11;
            default:  owner_d = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tgt_q       <= TGT_NONE;
            cnt_q       <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            fsm_reset_q <= 1'b1;
            owner_q     <= 2'b00;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            fsm_reset_q <= fsm_reset_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.ConfigWriteData   = data_q;
    assign bus.ConfigWriteStrobe = strobe_q;
    assign bus.FsmReset          = fsm_reset_q;
    assign bus.Owner             = owner_q;
    assign bus.cpu_drop          = drop_q;
endmodule

// File: tb/tb_config_port_arbiter.sv
// Bench for config_port_arbiter: vector table, directed corner cases
// and random traffic against a session-level reference model.
module tb_config_port_arbiter;
    localparam int TIMEOUT = 1024;

    logic CLK;
    logic resetn;
    config_port_arbiter_if bus ();

    config_port_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_WIDTH     (10)
    ) dut (
        .CLK   (CLK),
        .resetn(resetn),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // reference model: who holds the port, pending handover, idle run
    int          m_owner;
    int          m_ho;
    int          m_tgt;
    int          m_idle;
    logic [31:0] m_data;
    logic        e_stb;
    logic        e_fr;
    logic        e_drop;
    logic [1:0]  e_own;

    typedef struct {
        logic        rst_n;
        logic        ua;
        logic        us;
        logic [31:0] ud;
        logic        ba;
        logic        bs;
        logic [31:0] bd;
        logic        cs;
        logic [31:0] cd;
        logic        x_stb;
        logic [31:0] x_data;
        logic        x_fr;
        logic [1:0]  x_own;
        logic        x_drop;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic drive(logic ua, logic us, logic [31:0] ud,
                         logic ba, logic bs, logic [31:0] bd,
                         logic cs, logic [31:0] cd);
        bus.uart_active = ua;
        bus.uart_strobe = us;
        bus.uart_data   = ud;
        bus.bb_active   = ba;
        bus.bb_strobe   = bs;
        bus.bb_data     = bd;
        bus.cpu_strobe  = cs;
        bus.cpu_data    = cd;
    endtask

    task automatic deliver(int src);
        logic        s;
        logic [31:0] d;
        s = (src == 1) ? bus.uart_strobe :
            (src == 2) ? bus.bb_strobe : bus.cpu_strobe;
        d = (src == 1) ? bus.uart_data :
            (src == 2) ? bus.bb_data : bus.cpu_data;
        if (s) begin
            e_stb  = 1'b1;
            m_data = d;
        end
    endtask

    // priority code: 1 UART, 2 bit-bang, 3 CPU; lower number wins
    task automatic model_edge();
        int   best;
        int   w;
        logic keep;
        logic cfwd;
        cfwd  = 1'b0;
        e_stb = 1'b0;
        e_fr  = 1'b0;
        if (!resetn) begin
            m_owner = 0;
            m_ho    = 0;
            m_tgt   = 0;
            m_idle  = 0;
            m_data  = '0;
            e_fr    = 1'b1;
            e_drop  = 1'b0;
            e_own   = 2'b00;
            return;
        end
        best = bus.uart_active ? 1 : (bus.bb_active ? 2 : 0);
        if (m_ho != 0) begin
            m_ho    = 0;
            keep    = (m_tgt == 1) ? bus.uart_active : bus.bb_active;
            m_owner = keep ? m_tgt : 0;
            m_idle  = 0;
        end else if (m_owner == 0) begin
            w = (best != 0) ? best : (bus.cpu_strobe ? 3 : 0);
            if (w != 0) begin
                m_owner = w;
                m_idle  = 0;
                e_fr    = 1'b1;
                deliver(w);
                if (w == 3) cfwd = 1'b1;
            end
        end else begin
            keep = (m_owner == 1) ? bus.uart_active :
                   (m_owner == 2) ? bus.bb_active : 1'b1;
            if (best != 0 && best != m_owner &&
                (!keep || best < m_owner)) begin
                m_ho    = 1;
                m_tgt   = best;
                m_owner = 0;
                e_fr    = 1'b1;
            end else if (!keep) begin
                m_owner = 0;
            end else if (m_owner == 3) begin
                if (bus.cpu_strobe) begin
                    deliver(3);
                    cfwd   = 1'b1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT - 1) m_owner = 0;
                end
            end else begin
                deliver(m_owner);
            end
        end
        e_own  = 2'(m_owner);
        e_drop = bus.cpu_strobe & ~cfwd;
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge CLK);
        #1;
        chk({tag, ".strobe"}, 32'(bus.ConfigWriteStrobe), 32'(e_stb));
        chk({tag, ".data"}, bus.ConfigWriteData, m_data);
        chk({tag, ".fsmreset"}, 32'(bus.FsmReset), 32'(e_fr));
        chk({tag, ".owner"}, 32'(bus.Owner), 32'(e_own));
        chk({tag, ".cpu_drop"}, 32'(bus.cpu_drop), 32'(e_drop));
    endtask

    function automatic vec_t mk(logic r, logic ua, logic us,
                                logic [31:0] ud, logic ba, logic bs,
                                logic [31:0] bd, logic cs,
                                logic [31:0] cd, logic xs,
                                logic [31:0] xd, logic xf,
                                logic [1:0] xo, logic xdr);
        vec_t v;
        v.rst_n = r;  v.ua = ua; v.us = us; v.ud = ud;
        v.ba = ba;    v.bs = bs; v.bd = bd;
        v.cs = cs;    v.cd = cd;
        v.x_stb = xs; v.x_data = xd; v.x_fr = xf;
        v.x_own = xo; v.x_drop = xdr;
        return v;
    endfunction

    logic ua_r, ba_r;

    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(0, 1,1,32'h0000_0001, 0,0,0, 1,32'h0000_0002,
                     0,32'h0, 1,2'b00, 0);
        tbl[1]  = mk(0, 0,0,0, 1,1,32'h0000_0003, 1,32'h0000_0004,
                     0,32'h0, 1,2'b00, 0);
        tbl[2]  = mk(1, 0,0,0, 0,0,0, 0,0,
                     0,32'h0, 0,2'b00, 0);
        tbl[3]  = mk(1, 0,0,0, 0,0,0, 1,32'hDEAD_BEEF,
                     1,32'hDEAD_BEEF, 1,2'b11, 0);
        tbl[4]  = mk(1, 0,0,0, 0,0,0, 1,32'h1111_1111,
                     1,32'h1111_1111, 0,2'b11, 0);
        tbl[5]  = mk(1, 1,0,0, 0,0,0, 1,32'h2222_2222,
                     0,32'h1111_1111, 1,2'b00, 1);
        tbl[6]  = mk(1, 1,1,32'h9999_9999, 0,0,0, 0,0,
                     0,32'h1111_1111, 0,2'b01, 0);
        tbl[7]  = mk(1, 1,1,32'h1234_5678, 0,0,0, 0,0,
                     1,32'h1234_5678, 0,2'b01, 0);
        tbl[8]  = mk(1, 1,0,0, 1,1,32'hBBBB_0000, 1,32'h3333_3333,
                     0,32'h1234_5678, 0,2'b01, 1);
        tbl[9]  = mk(1, 0,0,0, 1,1,32'hBBBB_0001, 0,0,
                     0,32'h1234_5678, 1,2'b00, 0);
        tbl[10] = mk(1, 0,0,0, 1,1,32'hBBBB_0002, 0,0,
                     0,32'h1234_5678, 0,2'b10, 0);
        tbl[11] = mk(1, 0,0,0, 1,1,32'hB0B0_B0B0, 0,0,
                     1,32'hB0B0_B0B0, 0,2'b10, 0);
        tbl[12] = mk(1, 0,0,0, 0,1,32'hBBBB_0003, 0,0,
                     0,32'hB0B0_B0B0, 0,2'b00, 0);
        tbl[13] = mk(1, 1,1,32'hA5A5_A5A5, 1,1,32'hBBBB_0004,
                     1,32'h4444_4444,
                     1,32'hA5A5_A5A5, 1,2'b01, 1);
        tbl[14] = mk(1, 0,0,0, 0,0,0, 0,0,
                     0,32'hA5A5_A5A5, 0,2'b00, 0);
        tbl[15] = mk(0, 1,1,32'h5555_5555, 0,0,0, 0,0,
                     0,32'h0, 1,2'b00, 0);

        for (int i = 0; i < 16; i++) begin
            resetn = tbl[i].rst_n;
            drive(tbl[i].ua, tbl[i].us, tbl[i].ud,
                  tbl[i].ba, tbl[i].bs, tbl[i].bd,
                  tbl[i].cs, tbl[i].cd);
            tick($sformatf("vec%0d.model", i));
            chk($sformatf("vec%0d.strobe", i),
                32'(bus.ConfigWriteStrobe), 32'(tbl[i].x_stb));
            chk($sformatf("vec%0d.data", i),
                bus.ConfigWriteData, tbl[i].x_data);
            chk($sformatf("vec%0d.fsmreset", i),
                32'(bus.FsmReset), 32'(tbl[i].x_fr));
            chk($sformatf("vec%0d.owner", i),
                32'(bus.Owner), 32'(tbl[i].x_own));
            chk($sformatf("vec%0d.cpu_drop", i),
                32'(bus.cpu_drop), 32'(tbl[i].x_drop));
        end

        // CPU idle timeout, restarted by a strobe at idle cycle 1022
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("to.idle");
        drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        tick("to.grant");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1021; i++) tick("to.wait1");
        drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0002);
        tick("to.restart");
        chk("to.restart_stb", 32'(bus.ConfigWriteStrobe), 32'd1);
        chk("to.restart_own", 32'(bus.Owner), 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1022; i++) tick("to.wait2");
        chk("to.still_owner", 32'(bus.Owner), 32'd3);
        tick("to.expire");
        chk("to.expired_owner", 32'(bus.Owner), 32'd0);
        chk("to.expired_fr", 32'(bus.FsmReset), 32'd0);

        // reset during a UART burst, then re-grant on release
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick("mr.grant");
        chk("mr.grant_fr", 32'(bus.FsmReset), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h6000_0000 + 32'(i), 0, 0, 0, 0, 0);
            tick("mr.burst");
        end
        resetn = 1'b0;
        drive(1, 1, 32'h6000_0010, 0, 0, 0, 0, 0);
        tick("mr.rst0");
        tick("mr.rst1");
        chk("mr.rst_stb", 32'(bus.ConfigWriteStrobe), 32'd0);
        chk("mr.rst_own", 32'(bus.Owner), 32'd0);
        resetn = 1'b1;
        drive(1, 1, 32'h7777_7777, 0, 0, 0, 0, 0);
        tick("mr.regrant");
        chk("mr.regrant_own", 32'(bus.Owner), 32'd1);
        chk("mr.regrant_fr", 32'(bus.FsmReset), 32'd1);
        chk("mr.regrant_data", bus.ConfigWriteData, 32'h7777_7777);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick("mr.hold");
        chk("mr.hold_fr", 32'(bus.FsmReset), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("mr.end");

        // random sessions with occasional resets
        ua_r = 1'b0;
        ba_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) ua_r = ~ua_r;
            if ($urandom_range(0, 9) == 0)  ba_r = ~ba_r;
            resetn = ($urandom_range(0, 399) != 0);
            drive(ua_r, 1'($urandom_range(0, 1)), $urandom,
                  ba_r, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 2) == 0), $urandom);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
